// File: rtl/car_park_pkg.sv
// Shared FSM encodings and width helpers for the car park controller.
package car_park_pkg;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BAR_IN   = 2'd1;
    localparam logic [1:0] S_WAIT_PAY = 2'd2;
    localparam logic [1:0] S_BAR_OUT  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Never collapse to zero width, so single-slot or one-tick builds still elaborate.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/car_park_bar_timer.sv
// Bar hold timer: a load pulse opens the bar for exactly CYCLES clocks.
module bar_timer
    import car_park_pkg::*;
#(
    parameter int CYCLES = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic open,
    output logic last
);

    localparam int CW = cnt_width(CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            open <= 1'b0;
        end else if (load) begin
            cnt  <= CW'(CYCLES - 1);
            open <= 1'b1;
        end else if (open) begin
            if (cnt == '0) open <= 1'b0;
            else           cnt  <= cnt - CW'(1);
        end
    end

    // Final open cycle; the FSM leaves its bar state on the same edge the bar drops.
    assign last = open && (cnt == '0);

endmodule

// File: rtl/car_park_ctrl.sv
// Multi-slot car park controller: ticketing, hourly billing, entry/exit bars.
// Define CARPARK_FEE_CAP_EN to clamp the computed fee at MAX_FEE.
module car_park_ctrl
    import car_park_pkg::*;
#(
    parameter int N_SLOTS         = 5,
    parameter int TICKS_PER_HOUR  = 3600,
    parameter int TIME_W          = 16,
    parameter int FEE_PER_HOUR    = 1,
    parameter int FEE_W           = 8,
    parameter int MAX_FEE         = 5,
    parameter int BAR_OPEN_CYCLES = 5000,
    localparam int ID_W           = id_width(N_SLOTS),
    localparam int CNT_W          = cnt_width(N_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sout,
    input  logic [ID_W-1:0]  ticket_id,
    input  logic             pay,
    output logic             bin,
    output logic             bout,
    output logic [ID_W-1:0]  ticket_out,
    output logic             ticket_valid,
    output logic [FEE_W-1:0] fee,
    output logic             fee_valid,
    output logic             err_bad_ticket,
    output logic [CNT_W-1:0] free_slots,
    output logic             full
);

    localparam int PW = id_width(TICKS_PER_HOUR);
    localparam int RW = TIME_W + 33;

    logic [1:0]        state;
    logic              sin_q, sout_q, pay_q;
    logic              ent_pend, ex_pend;
    logic [ID_W-1:0]   ex_tid, cur_slot;
    logic [N_SLOTS-1:0] occ;
    logic [TIME_W-1:0] etime [N_SLOTS];
    logic [PW-1:0]     presc;
    logic [TIME_W-1:0] hour;

    logic [ID_W-1:0]   free_idx;
    logic              have_free, ex_occ;
    logic [TIME_W-1:0] ex_etime, stay;
    logic [RW-1:0]     raw_fee;
    logic [FEE_W-1:0]  fee_sat, fee_due;
    logic              ex_take, ent_take, pay_take;
    logic              bin_last, bout_last;

`ifndef CARPARK_FEE_CAP_EN
    logic unused_max_fee;
    assign unused_max_fee = ^MAX_FEE;
`endif

    // Lowest-index free slot wins.
    always_comb begin
        free_idx  = '0;
        have_free = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                free_idx  = ID_W'(i);
                have_free = 1'b1;
            end
        end
    end

    // Out-of-range ticket ids match no slot and read as unoccupied.
    always_comb begin
        ex_occ   = 1'b0;
        ex_etime = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (ex_tid == ID_W'(i)) begin
                ex_occ   = occ[i];
                ex_etime = etime[i];
            end
        end
    end

    // Hour difference wraps mod 2^TIME_W, so stays beyond that are undercharged.
    always_comb begin
        stay    = hour - ex_etime;
        raw_fee = (RW'(stay) + RW'(1)) * RW'(FEE_PER_HOUR);
        fee_sat = (|raw_fee[RW-1:FEE_W]) ? '1 : raw_fee[FEE_W-1:0];
`ifdef CARPARK_FEE_CAP_EN
        fee_due = (fee_sat > FEE_W'(MAX_FEE)) ? FEE_W'(MAX_FEE) : fee_sat;
`else
        fee_due = fee_sat;
`endif
    end

    // Exit before entry: freeing capacity first can unblock a waiting car.
    assign ex_take  = (state == S_IDLE) && ex_pend;
    assign ent_take = (state == S_IDLE) && !ex_pend && ent_pend && have_free;
    assign pay_take = (state == S_WAIT_PAY) && pay_q;

    bar_timer #(.CYCLES(BAR_OPEN_CYCLES)) u_bar_in (
        .clk  (clk),
        .rst  (rst),
        .load (ent_take),
        .open (bin),
        .last (bin_last)
    );

    bar_timer #(.CYCLES(BAR_OPEN_CYCLES)) u_bar_out (
        .clk  (clk),
        .rst  (rst),
        .load (pay_take),
        .open (bout),
        .last (bout_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_q    <= 1'b0;
            sout_q   <= 1'b0;
            pay_q    <= 1'b0;
            ent_pend <= 1'b0;
            ex_pend  <= 1'b0;
            ex_tid   <= '0;
            presc    <= '0;
            hour     <= '0;
        end else begin
            sin_q    <= sin;
            sout_q   <= sout;
            pay_q    <= pay;
            ent_pend <= (ent_pend && !ent_take) || (sin && !sin_q);
            ex_pend  <= (ex_pend && !ex_take) || (sout && !sout_q);
            if (sout && !sout_q) ex_tid <= ticket_id;
            if (presc == PW'(TICKS_PER_HOUR - 1)) begin
                presc <= '0;
                hour  <= hour + TIME_W'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < N_SLOTS; i++) etime[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (ent_take && free_idx == ID_W'(i)) begin
                    occ[i]   <= 1'b1;
                    etime[i] <= hour;
                end else if (pay_take && cur_slot == ID_W'(i)) begin
                    occ[i]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cur_slot       <= '0;
            ticket_out     <= '0;
            ticket_valid   <= 1'b0;
            fee            <= '0;
            fee_valid      <= 1'b0;
            err_bad_ticket <= 1'b0;
            free_slots     <= CNT_W'(N_SLOTS);
            full           <= 1'b0;
        end else begin
            ticket_valid   <= 1'b0;
            err_bad_ticket <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_take) begin
                        if (ex_occ) begin
                            fee       <= fee_due;
                            fee_valid <= 1'b1;
                            cur_slot  <= ex_tid;
                            state     <= S_WAIT_PAY;
                        end else begin
                            err_bad_ticket <= 1'b1;
                        end
                    end else if (ent_take) begin
                        ticket_out   <= free_idx;
                        ticket_valid <= 1'b1;
                        free_slots   <= free_slots - CNT_W'(1);
                        full         <= (free_slots == CNT_W'(1));
                        state        <= S_BAR_IN;
                    end
                end
                S_BAR_IN: if (bin_last) state <= S_IDLE;
                S_WAIT_PAY: begin
                    if (pay_take) begin
                        fee        <= '0;
                        fee_valid  <= 1'b0;
                        free_slots <= free_slots + CNT_W'(1);
                        full       <= 1'b0;
                        state      <= S_BAR_OUT;
                    end
                end
                S_BAR_OUT: if (bout_last) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_park_ctrl.sv
// Directed bench for car_park_ctrl: entry, full/pending, billing, bad ticket, priority, reset.
module tb_car_park_ctrl;

    logic       clk, rst, sin, sout, pay;
    logic [2:0] ticket_id;
    logic       bin, bout, ticket_valid, fee_valid, err_bad_ticket, full;
    logic [2:0] ticket_out;
    logic [7:0] fee;
    logic [2:0] free_slots;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    car_park_ctrl dut (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout), .ticket_id(ticket_id), .pay(pay),
        .bin(bin), .bout(bout), .ticket_out(ticket_out), .ticket_valid(ticket_valid),
        .fee(fee), .fee_valid(fee_valid), .err_bad_ticket(err_bad_ticket),
        .free_slots(free_slots), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Entry pulse; returns what was seen one edge after the sampled sin edge, then waits for the bar to drop.
    task automatic car_in(output logic [2:0] t, output logic tv, output logic b);
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b0;
        @(negedge clk);
        t  = ticket_out;
        tv = ticket_valid;
        b  = bin;
        repeat (5000) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sin = 0; sout = 0; pay = 0; ticket_id = 0;
        repeat (3) @(negedge clk);
        checks++; if ({bin, bout, ticket_valid, fee_valid, err_bad_ticket, full} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {bin, bout, ticket_valid, fee_valid, err_bad_ticket, full}); else passed++;
        checks++; if (ticket_out !== 3'd0 || fee !== 8'd0)
            $display("FAIL reset_data ticket_out=%0d fee=%0d want 0 0", ticket_out, fee); else passed++;
        checks++; if (free_slots !== 3'd5) $display("FAIL reset_free got %0d want 5", free_slots); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_entry();
        int n;
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b0;
        checks++; if (bin !== 1'b0) $display("FAIL entry_early_bin got %b want 0", bin); else passed++;
        @(negedge clk);
        checks++; if (bin !== 1'b1 || ticket_valid !== 1'b1 || ticket_out !== 3'd0)
            $display("FAIL entry_issue bin=%b tv=%b ticket=%0d want 1 1 0", bin, ticket_valid, ticket_out); else passed++;
        checks++; if (free_slots !== 3'd4) $display("FAIL entry_free got %0d want 4", free_slots); else passed++;
        @(negedge clk);
        checks++; if (ticket_valid !== 1'b0) $display("FAIL entry_tv_pulse got %b want 0", ticket_valid); else passed++;
        n = 2;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (bin === 1'b1) n++;
            else break;
        end
        checks++; if (n !== 5000) $display("FAIL entry_bar_len got %0d want 5000", n); else passed++;
    endtask

    task automatic test_full();
        logic [2:0] t;
        logic tv, b;
        for (int i = 1; i <= 4; i++) begin
            car_in(t, tv, b);
            checks++; if (t !== 3'(i) || tv !== 1'b1 || b !== 1'b1)
                $display("FAIL full_fill%0d ticket=%0d tv=%b bin=%b want %0d 1 1", i, t, tv, b, i); else passed++;
        end
        checks++; if (full !== 1'b1 || free_slots !== 3'd0)
            $display("FAIL full_flag full=%b free=%0d want 1 0", full, free_slots); else passed++;
        sin = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (bin !== 1'b0 || ticket_valid !== 1'b0)
            $display("FAIL full_blocked bin=%b tv=%b want 0 0", bin, ticket_valid); else passed++;
        sin = 1'b0;
        sout = 1'b1; ticket_id = 3'd2;
        @(negedge clk);
        sout = 1'b0;
        @(negedge clk);
        checks++; if (fee_valid !== 1'b1 || err_bad_ticket !== 1'b0)
            $display("FAIL full_exit fee_valid=%b err=%b want 1 0", fee_valid, err_bad_ticket); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (fee_valid !== 1'b1 || bin !== 1'b0)
            $display("FAIL full_wait fee_valid=%b bin=%b want 1 0", fee_valid, bin); else passed++;
        pay = 1'b1;
        @(negedge clk);
        pay = 1'b0;
        @(negedge clk);
        checks++; if (bout !== 1'b1 || fee_valid !== 1'b0 || free_slots !== 3'd1 || full !== 1'b0)
            $display("FAIL full_paid bout=%b fv=%b free=%0d full=%b want 1 0 1 0", bout, fee_valid, free_slots, full); else passed++;
        repeat (5000) @(negedge clk);
        checks++; if (bout !== 1'b0 || bin !== 1'b0)
            $display("FAIL full_bout_end bout=%b bin=%b want 0 0", bout, bin); else passed++;
        @(negedge clk);
        checks++; if (bin !== 1'b1 || ticket_valid !== 1'b1 || ticket_out !== 3'd2 || full !== 1'b1)
            $display("FAIL full_reuse bin=%b tv=%b ticket=%0d full=%b want 1 1 2 1", bin, ticket_valid, ticket_out, full); else passed++;
    endtask

    task automatic test_fee();
        logic [2:0] t;
        logic tv, b;
        int n;
        apply_reset();
        car_in(t, tv, b);
        checks++; if (t !== 3'd0 || tv !== 1'b1) $display("FAIL fee_car0 ticket=%0d tv=%b want 0 1", t, tv); else passed++;
        car_in(t, tv, b);
        checks++; if (t !== 3'd1 || tv !== 1'b1) $display("FAIL fee_car1 ticket=%0d tv=%b want 1 1", t, tv); else passed++;
        while (cyc < 10100) @(negedge clk);
        sout = 1'b1; ticket_id = 3'd0;
        @(negedge clk);
        sout = 1'b0;
        @(negedge clk);
        checks++; if (fee_valid !== 1'b1 || fee !== 8'd3)
            $display("FAIL fee_2h fee_valid=%b fee=%0d want 1 3", fee_valid, fee); else passed++;
        repeat (10) @(negedge clk);
        checks++; if (fee_valid !== 1'b1 || fee !== 8'd3 || bout !== 1'b0)
            $display("FAIL fee_hold fv=%b fee=%0d bout=%b want 1 3 0", fee_valid, fee, bout); else passed++;
        pay = 1'b1;
        @(negedge clk);
        pay = 1'b0;
        checks++; if (bout !== 1'b0) $display("FAIL fee_pay_early bout=%b want 0", bout); else passed++;
        @(negedge clk);
        checks++; if (bout !== 1'b1 || fee !== 8'd0 || fee_valid !== 1'b0 || free_slots !== 3'd4)
            $display("FAIL fee_paid bout=%b fee=%0d fv=%b free=%0d want 1 0 0 4", bout, fee, fee_valid, free_slots); else passed++;
        n = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (bout === 1'b1) n++;
            else break;
        end
        checks++; if (n !== 5000) $display("FAIL fee_bout_len got %0d want 5000", n); else passed++;
    endtask

    task automatic test_bad_ticket();
        logic [2:0] ids [2];
        ids[0] = 3'd3;
        ids[1] = 3'd6;
        for (int i = 0; i < 2; i++) begin
            sout = 1'b1; ticket_id = ids[i];
            @(negedge clk);
            sout = 1'b0;
            @(negedge clk);
            checks++; if (err_bad_ticket !== 1'b1 || fee_valid !== 1'b0)
                $display("FAIL bad_ticket%0d err=%b fv=%b want 1 0", ids[i], err_bad_ticket, fee_valid); else passed++;
            @(negedge clk);
            checks++; if (err_bad_ticket !== 1'b0 || fee_valid !== 1'b0 || bout !== 1'b0)
                $display("FAIL bad_pulse%0d err=%b fv=%b bout=%b want 0 0 0", ids[i], err_bad_ticket, fee_valid, bout); else passed++;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_fee;
`ifdef CARPARK_FEE_CAP_EN
        exp_fee = 8'd5;
`else
        exp_fee = 8'd10;
`endif
        while (cyc < 37000) @(negedge clk);
        sin = 1'b1; sout = 1'b1; ticket_id = 3'd1;
        @(negedge clk);
        sin = 1'b0; sout = 1'b0;
        @(negedge clk);
        checks++; if (fee_valid !== 1'b1 || bin !== 1'b0 || ticket_valid !== 1'b0)
            $display("FAIL simul_exit_first fv=%b bin=%b tv=%b want 1 0 0", fee_valid, bin, ticket_valid); else passed++;
        checks++; if (fee !== exp_fee) $display("FAIL simul_fee_9h got %0d want %0d", fee, exp_fee); else passed++;
        pay = 1'b1;
        @(negedge clk);
        pay = 1'b0;
        @(negedge clk);
        checks++; if (bout !== 1'b1 || bin !== 1'b0 || free_slots !== 3'd5)
            $display("FAIL simul_paid bout=%b bin=%b free=%0d want 1 0 5", bout, bin, free_slots); else passed++;
        repeat (5000) @(negedge clk);
        checks++; if (bout !== 1'b0 || bin !== 1'b0)
            $display("FAIL simul_gap bout=%b bin=%b want 0 0", bout, bin); else passed++;
        @(negedge clk);
        checks++; if (bin !== 1'b1 || ticket_valid !== 1'b1 || ticket_out !== 3'd0 || free_slots !== 3'd4)
            $display("FAIL simul_entry bin=%b tv=%b ticket=%0d free=%0d want 1 1 0 4", bin, ticket_valid, ticket_out, free_slots); else passed++;
    endtask

    task automatic test_reset_mid_bar();
        repeat (100) @(negedge clk);
        checks++; if (bin !== 1'b1) $display("FAIL midbar_open got %b want 1", bin); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (bin !== 1'b0 || free_slots !== 3'd5 || full !== 1'b0)
            $display("FAIL midbar_reset bin=%b free=%0d full=%b want 0 5 0", bin, free_slots, full); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bin !== 1'b0 || bout !== 1'b0 || ticket_valid !== 1'b0)
            $display("FAIL midbar_quiet bin=%b bout=%b tv=%b want 0 0 0", bin, bout, ticket_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_full();
        test_fee();
        test_bad_ticket();
        test_simultaneous();
        test_reset_mid_bar();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/car_park_ctrl.md
# car_park_ctrl

Multi-slot car park controller, parametrised successor of the single-lane car park FSM. Allocates a numbered ticket per entering car, timestamps it against a free-running hour counter, computes a per-started-hour fee at exit, waits for payment, and drives entry/exit bars for a fixed open time. Sits between the lane sensors/pay terminal and the bar actuators and occupancy display.

## Interface
- N_SLOTS, 5: parking places (1..64); ID_W = clog2(N_SLOTS), CNT_W = clog2(N_SLOTS+1) derived
- TICKS_PER_HOUR, 3600: clk cycles per billing hour
- TIME_W, 16: hour counter width
- FEE_PER_HOUR, 1: fee units per started hour
- FEE_W, 8: fee width
- MAX_FEE, 5: fee ceiling (used only with CARPARK_FEE_CAP_EN)
- BAR_OPEN_CYCLES, 5000: bar open time in cycles
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- sin  in  1  entry sensor, synchronous level
- sout  in  1  exit sensor, synchronous level
- ticket_id  in  ID_W  ticket presented at exit, sampled with sout edge
- pay  in  1  payment confirmed, level
- bin  out  1  entry bar open
- bout  out  1  exit bar open
- ticket_out  out  ID_W  issued ticket (slot index)
- ticket_valid  out  1  one-cycle pulse, ticket_out valid
- fee  out  FEE_W  amount due
- fee_valid  out  1  high while waiting for payment
- err_bad_ticket  out  1  one-cycle pulse, presented ticket not occupied
- free_slots  out  CNT_W  free places
- full  out  1  free_slots == 0

## Operation
- States: IDLE, BAR_IN, WAIT_PAY, BAR_OUT.
- Event = sensor rising edge (sampled high, previous sample low). Edge flags registered; an edge arriving outside IDLE is held pending until IDLE.
- IDLE: pending exit has priority over pending entry (frees capacity first).
- Entry: if full, request stays pending (not dropped) until a slot frees. Else allocate lowest-index free slot, store current hour, issue ticket, free_slots−1, go BAR_IN.
- Exit: if slot[ticket_id] not occupied or ticket_id ≥ N_SLOTS -> err_bad_ticket pulse, drop request, stay IDLE. Else fee = ((now − entry) mod 2^TIME_W + 1) × FEE_PER_HOUR, saturated at 2^FEE_W−1; go WAIT_PAY.
- WAIT_PAY: fee/fee_valid held; pay high -> free slot, free_slots+1, go BAR_OUT. No timeout.
- BAR_IN/BAR_OUT: bar open exactly BAR_OPEN_CYCLES cycles, then IDLE.
- Hour counter: prescaler to TICKS_PER_HOUR, wraps at 2^TIME_W; stays ≥ 2^TIME_W hours are undercharged (documented limitation).

## Timing
- Reset (async, any state): state IDLE, all slots free, bin=bout=0, ticket_valid=fee_valid=err_bad_ticket=0, ticket_out=0, fee=0, free_slots=N_SLOTS, full=0, counters 0, pending flags cleared.
- Entry: sin edge sampled at edge k -> bin=1, ticket_valid pulse, free_slots updated at edge k+1; bin falls at edge k+1+BAR_OPEN_CYCLES; next event served from edge k+2+BAR_OPEN_CYCLES.
- Exit: sout edge at k -> fee_valid=1 (or err pulse) at k+1; pay sampled high at m -> bout=1, fee_valid=0, fee=0, free_slots updated at m+1.
- All outputs registered.

## Configuration
- CARPARK_FEE_CAP_EN defined: fee = min(computed fee, MAX_FEE).
- Undefined: fee uncapped, only FEE_W saturation; MAX_FEE ignored.

## Structure
- car_park_pkg: state encodings, clog2 function, ID_W/CNT_W derivation.
- Sub-module bar_timer (load, count down BAR_OPEN_CYCLES, open output), instantiated twice.

## Test plan
- Reset then sin edge, N_SLOTS=5 -> ticket_out=0, bin high exactly 5000 cycles, free_slots=4.
- 5 entries, 6th sin held high -> full=1, no bin; exit+pay of ticket 2 -> 6th car gets ticket 2.
- Entry, wait 2.5 hours, sout with ticket -> fee=3; pay -> bout 5000 cycles, free_slots restored.
- sout with unoccupied ticket 3 -> err_bad_ticket one pulse, state IDLE, no fee_valid.
- sin and sout edges same cycle -> exit served first, entry served after BAR_OUT.
- CARPARK_FEE_CAP_EN, 9-hour stay -> fee=5; without macro fee=10. Reset asserted mid-BAR_IN -> bin=0 immediately, free_slots=5.
